// File: rtl/gmii_frame_gen.sv
// gmii_frame_gen: builds Ethernet frames from a one-shot command and drives them on GMII TX
module gmii_frame_gen #(
    parameter int IFG_CYCLES  = 12,
    parameter int PRE_LEN     = 7,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic        gtx_clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [47:0] cmd_dst,
    input  logic [47:0] cmd_src,
    input  logic [15:0] cmd_type,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  cmd_seed,
    input  logic        cmd_err_en,
    input  logic [15:0] cmd_err_idx,
    output logic        gmii_gtxc,
    output logic [7:0]  gmii_txd,
    output logic        gmii_txen,
    output logic        gmii_txer,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_HDR  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
    localparam logic [2:0] S_PAD  = 3'd5;
    localparam logic [2:0] S_FCS  = 3'd6;
    localparam logic [2:0] S_IFG  = 3'd7;

    localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 2);
    localparam logic [15:0] MIN_PAY  = 16'(MIN_PAYLOAD);
    localparam logic [15:0] MAX_PAY  = 16'(MAX_PAYLOAD);

    logic [2:0]   state_q, state_d, nxt;
    logic [15:0]  cnt_q, cnt_d, idx_q, idx_d;
    logic [31:0]  crc_q, crc_d;
    logic [111:0] hdr_q, hdr_d;
    logic [15:0]  len_q, pad_q, err_idx_q;
    logic [7:0]   seed_q;
    logic         err_en_q;
    logic [7:0]   txd_q, txd_d;
    logic         txen_q, txen_d, txer_q, txer_d, done_q, done_d, ready_q;
    logic [15:0]  frame_cnt_q;
    logic         last, accept;
    logic [15:0]  len_c, pad_c;

    function automatic logic in_frame(input logic [2:0] s);
        return s == S_HDR || s == S_PAY || s == S_PAD || s == S_FCS;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign len_c     = cmd_len > MAX_PAY ? MAX_PAY : cmd_len;
    assign pad_c     = len_c < MIN_PAY ? MIN_PAY - len_c : '0;
    assign accept    = state_q == S_IDLE && cmd_valid;
    assign gmii_gtxc = gtx_clk;
    assign cmd_ready = ready_q;
    assign gmii_txd  = txd_q;
    assign gmii_txen = txen_q;
    assign gmii_txer = txer_q;
    assign frame_done = done_q;
    assign frame_cnt = frame_cnt_q;

    // Sequencer: each state lasts a fixed or latched number of cycles; the IFG state is one
    // short because the IDLE cycle in which the next command is taken completes the gap.
    always_comb begin
        last = 1'b0;
        nxt  = S_IDLE;
        case (state_q)
            S_IDLE:  begin last = cmd_valid;             nxt = S_PRE; end
            S_PRE:   begin last = cnt_q == PRE_LAST;     nxt = S_SFD; end
            S_SFD:   begin last = 1'b1;                  nxt = S_HDR; end
            S_HDR:   begin last = cnt_q == 16'd13;       nxt = len_q != '0 ? S_PAY : pad_q != '0 ? S_PAD : S_FCS; end
            S_PAY:   begin last = cnt_q == len_q - 16'd1; nxt = pad_q != '0 ? S_PAD : S_FCS; end
            S_PAD:   begin last = cnt_q == pad_q - 16'd1; nxt = S_FCS; end
            S_FCS:   begin last = cnt_q == 16'd3;        nxt = S_IFG; end
            default: begin last = cnt_q == IFG_LAST;     nxt = S_IDLE; end
        endcase
        state_d = last ? nxt : state_q;
        cnt_d   = last ? '0 : cnt_q + 16'd1;
    end

    // Outputs are computed for the state being entered so they leave the flops already aligned.
    always_comb begin
        txd_d  = state_d == S_PRE ? 8'h55 :
                 state_d == S_SFD ? 8'hD5 :
                 state_d == S_HDR ? hdr_q[111:104] :
                 state_d == S_PAY ? seed_q + cnt_d[7:0] :
                 state_d == S_FCS ? ~crc_q[7:0] : 8'h00;
        hdr_d  = accept ? {cmd_dst, cmd_src, cmd_type} : state_d == S_HDR ? hdr_q << 8 : hdr_q;
        crc_d  = accept ? 32'hFFFFFFFF :
                 in_frame(state_d) && state_d != S_FCS ? crc_byte(crc_q, txd_d) :
                 state_d == S_FCS ? crc_q >> 8 : crc_q;
        idx_d  = state_q == S_SFD ? '0 : in_frame(state_q) ? idx_q + 16'd1 : idx_q;
        txen_d = state_d != S_IDLE && state_d != S_IFG;
        txer_d = err_en_q && in_frame(state_d) && idx_d == err_idx_q;
        done_d = state_q == S_FCS && state_d == S_IFG;
    end

    // Frame state, CRC and registered GMII outputs.
    always_ff @(posedge gtx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            crc_q       <= 32'hFFFFFFFF;
            hdr_q       <= '0;
            txd_q       <= '0;
            txen_q      <= 1'b0;
            txer_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            crc_q       <= crc_d;
            hdr_q       <= hdr_d;
            txd_q       <= txd_d;
            txen_q      <= txen_d;
            txer_q      <= txer_d;
            done_q      <= done_d;
            ready_q     <= state_d == S_IDLE;
            frame_cnt_q <= frame_cnt_q + {15'd0, done_d};
        end
    end

    // Command fields held for the whole frame, with the payload length already clamped.
    always_ff @(posedge gtx_clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q     <= '0;
            pad_q     <= '0;
            seed_q    <= '0;
            err_en_q  <= 1'b0;
            err_idx_q <= '0;
        end else if (accept) begin
            len_q     <= len_c;
            pad_q     <= pad_c;
            seed_q    <= cmd_seed;
            err_en_q  <= cmd_err_en;
            err_idx_q <= cmd_err_idx;
        end
    end
endmodule

// File: tb/tb_gmii_frame_gen.sv
// tb_gmii_frame_gen: vector table plus scoreboard checking of generated GMII frames
module tb_gmii_frame_gen;
    logic        gtx_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [47:0] cmd_dst = '0, cmd_src = '0;
    logic [15:0] cmd_type = '0, cmd_len = '0, cmd_err_idx = '0;
    logic [7:0]  cmd_seed = '0;
    logic        cmd_err_en = 1'b0;
    logic        gmii_gtxc, gmii_txen, gmii_txer, frame_done;
    logic [7:0]  gmii_txd;
    logic [15:0] frame_cnt;

    int checks = 0, passed = 0;

    always #4 gtx_clk = ~gtx_clk;

    gmii_frame_gen dut (
        .gtx_clk(gtx_clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_type(cmd_type), .cmd_len(cmd_len),
        .cmd_seed(cmd_seed), .cmd_err_en(cmd_err_en), .cmd_err_idx(cmd_err_idx),
        .gmii_gtxc(gmii_gtxc), .gmii_txd(gmii_txd), .gmii_txen(gmii_txen), .gmii_txer(gmii_txer),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    // Scoreboard: {txer, txd} expected for every txen cycle
    logic [8:0] exp_q[$];
    int gaps[$], lens[$];
    int run_len = 0, txer_cnt = 0, txer_pos = 0, idle_cnt = 0, done_cnt = 0;
    int last_len = 0, last_txer_cnt = 0, last_txer_pos = 0;
    logic [31:0] res_crc = '0, last_res = '0;
    logic prev_txen = 1'b0, have_prev = 1'b0;
    logic [8:0] e;

    task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int len, input logic [7:0] seed, input logic een, input int eidx);
        logic [7:0] b[$];
        logic [31:0] c;
        int l, p;
        l = len > 1500 ? 1500 : len;
        p = l < 46 ? 46 - l : 0;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int i = 0; i < 6; i++) b.push_back(d[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(s[47 - 8*i -: 8]);
        b.push_back(t[15:8]);
        b.push_back(t[7:0]);
        for (int i = 0; i < l; i++) b.push_back(seed + 8'(i));
        for (int i = 0; i < p; i++) b.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (b[j]) c = crc8(c, b[j]);
        c = ~c;
        for (int k = 0; k < 4; k++) b.push_back(c[8*k +: 8]);
        foreach (b[j]) exp_q.push_back({een && j == eidx, b[j]});
    endtask

    // Monitor on the falling edge, away from the active edge
    always @(negedge gtx_clk) begin
        if (!reset_n) begin
            exp_q.delete();
            run_len = 0; txer_cnt = 0; txer_pos = 0; idle_cnt = 0;
            prev_txen = 1'b0; have_prev = 1'b0;
        end else begin
            chk("frame_done", frame_done, prev_txen && !gmii_txen);
            if (frame_done) done_cnt++;
            if (gmii_txen) begin
                if (run_len == 0 && have_prev) gaps.push_back(idle_cnt);
                run_len++;
                if (run_len == 1) res_crc = 32'hFFFFFFFF;
                else if (run_len > 8) res_crc = crc8(res_crc, gmii_txd);
                if (gmii_txer) begin txer_cnt++; txer_pos = run_len; end
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected byte: got %0h at txen cycle %0d, expected none", gmii_txd, run_len);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("txd[%0d]", run_len), gmii_txd, e[7:0]);
                    chk($sformatf("txer[%0d]", run_len), gmii_txer, e[8]);
                end
            end else begin
                chk("idle txd/txer", {gmii_txd, gmii_txer}, 0);
                if (run_len > 0) begin
                    last_len = run_len; last_txer_cnt = txer_cnt; last_txer_pos = txer_pos;
                    last_res = res_crc; lens.push_back(run_len); have_prev = 1'b1;
                    run_len = 0; txer_cnt = 0; txer_pos = 0; idle_cnt = 0;
                end
                idle_cnt++;
            end
            prev_txen = gmii_txen;
        end
    end

    typedef struct {
        logic [47:0] dst, src;
        logic [15:0] typ, len;
        logic [7:0]  seed;
        logic        een;
        logic [15:0] eidx;
        int          exp_len, exp_pos;
    } vec_t;

    function automatic vec_t mk(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                                input logic [15:0] l, input logic [7:0] sd, input logic een,
                                input logic [15:0] ei, input int el, input int ep);
        vec_t v;
        v.dst = d; v.src = s; v.typ = t; v.len = l; v.seed = sd;
        v.een = een; v.eidx = ei; v.exp_len = el; v.exp_pos = ep;
        return v;
    endfunction

    task automatic wait_ready();
        @(negedge gtx_clk);
        for (int n = 0; n < 4000 && !cmd_ready; n++) @(negedge gtx_clk);
        if (!cmd_ready) fail("wait cmd_ready");
    endtask

    task automatic drive(input vec_t v);
        cmd_dst = v.dst; cmd_src = v.src; cmd_type = v.typ; cmd_len = v.len;
        cmd_seed = v.seed; cmd_err_en = v.een; cmd_err_idx = v.eidx;
        push_frame(v.dst, v.src, v.typ, int'(v.len), v.seed, v.een, int'(v.eidx));
        cmd_valid = 1'b1;
        @(posedge gtx_clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin @(negedge gtx_clk); n++; end while (!frame_done && n < 3000);
        #1;
        if (!frame_done) fail("wait frame_done");
    endtask

    vec_t tbl[13];
    int acc, base;

    initial begin
        tbl[0]  = mk(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h0800, 16'd0,     8'h00, 1'b0, 16'd0,   72,   0);
        tbl[1]  = mk(48'hFF_FF_FF_FF_FF_FF, 48'h00_11_22_33_44_55, 16'h0800, 16'd100,   8'hF0, 1'b0, 16'd0,   126,  0);
        tbl[2]  = mk(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h88B5, 16'd60,    8'h11, 1'b1, 16'd20,  86,   29);
        tbl[3]  = mk(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h88B5, 16'd60,    8'h11, 1'b1, 16'd200, 86,   0);
        tbl[4]  = mk(48'h0A_0B_0C_0D_0E_0F, 48'h10_20_30_40_50_60, 16'h86DD, 16'h2000,  8'h3C, 1'b0, 16'd0,   1526, 0);
        tbl[5]  = mk(48'h0A_0B_0C_0D_0E_0F, 48'h10_20_30_40_50_60, 16'h0800, 16'd45,    8'hA5, 1'b0, 16'd0,   72,   0);
        tbl[6]  = mk(48'h0A_0B_0C_0D_0E_0F, 48'h10_20_30_40_50_60, 16'h0800, 16'd46,    8'h5A, 1'b0, 16'd0,   72,   0);
        tbl[7]  = mk(48'h0A_0B_0C_0D_0E_0F, 48'h10_20_30_40_50_60, 16'h0800, 16'd47,    8'hFE, 1'b0, 16'd0,   73,   0);
        tbl[8]  = mk(48'h01_23_45_67_89_AB, 48'hCD_EF_01_23_45_67, 16'h0806, 16'd1500,  8'h80, 1'b0, 16'd0,   1526, 0);
        tbl[9]  = mk(48'h01_23_45_67_89_AB, 48'hCD_EF_01_23_45_67, 16'h0806, 16'd1501,  8'h80, 1'b0, 16'd0,   1526, 0);
        tbl[10] = mk(48'h0A_0B_0C_0D_0E_0F, 48'h10_20_30_40_50_60, 16'h0800, 16'd46,    8'h00, 1'b1, 16'd63,  72,   72);
        tbl[11] = mk(48'h0A_0B_0C_0D_0E_0F, 48'h10_20_30_40_50_60, 16'h0800, 16'd0,     8'h00, 1'b0, 16'd5,   72,   0);
        tbl[12] = mk(48'h0A_0B_0C_0D_0E_0F, 48'h10_20_30_40_50_60, 16'h0800, 16'd10,    8'h77, 1'b1, 16'd0,   72,   9);

        repeat (3) @(negedge gtx_clk);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset txd", gmii_txd, 0);
        chk("reset txen", gmii_txen, 0);
        chk("reset txer", gmii_txer, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset frame_cnt", frame_cnt, 0);
        @(posedge gtx_clk); #1 chk("gtxc high", gmii_gtxc, 1);
        @(negedge gtx_clk); #1 chk("gtxc low", gmii_gtxc, 0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            wait_ready();
            drive(tbl[i]);
            chk($sformatf("v%0d busy cmd_ready", i), cmd_ready, 0);
            wait_done();
            chk($sformatf("v%0d txen length", i), last_len, tbl[i].exp_len);
            chk($sformatf("v%0d txer count", i), last_txer_cnt, tbl[i].exp_pos != 0);
            chk($sformatf("v%0d txer position", i), last_txer_pos, tbl[i].exp_pos);
            chk($sformatf("v%0d crc residue", i), last_res, 32'hDEBB20E3);
            chk($sformatf("v%0d scoreboard drained", i), exp_q.size(), 0);
            chk($sformatf("v%0d frame_cnt", i), frame_cnt, i + 1);
        end

        // Reset dropped while payload byte 10 is on the wire
        wait_ready();
        drive(mk(48'hFF_FF_FF_FF_FF_FF, 48'h00_11_22_33_44_55, 16'h0800, 16'd100, 8'h40, 1'b0, 16'd0, 0, 0));
        for (int n = 0; n < 500 && run_len != 33; n++) begin @(negedge gtx_clk); #1; end
        chk("reached payload byte 10", run_len, 33);
        chk("payload byte 10", gmii_txd, 8'h4A);
        base = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("async reset txen", gmii_txen, 0);
        chk("async reset txer", gmii_txer, 0);
        chk("async reset txd", gmii_txd, 0);
        chk("async reset frame_cnt", frame_cnt, 0);
        chk("async reset cmd_ready", cmd_ready, 1);
        repeat (3) @(negedge gtx_clk);
        #2 reset_n = 1'b1;
        repeat (20) @(negedge gtx_clk);
        #1;
        chk("cmd_ready after release", cmd_ready, 1);
        chk("no frame_done after truncation", done_cnt, base);
        chk("frame_cnt after release", frame_cnt, 0);

        // Back-to-back: cmd_valid held across three frames
        gaps.delete();
        lens.delete();
        base = done_cnt;
        acc = 0;
        cmd_dst = 48'h02_AA_BB_CC_DD_EE; cmd_src = 48'h02_11_22_33_44_55; cmd_type = 16'h0800;
        cmd_len = 16'd46; cmd_seed = 8'h01; cmd_err_en = 1'b0; cmd_err_idx = 16'd0;
        for (int k = 0; k < 3; k++) push_frame(cmd_dst, cmd_src, cmd_type, 46, 8'h01, 1'b0, 0);
        @(negedge gtx_clk);
        cmd_valid = 1'b1;
        for (int n = 0; n < 1000 && acc < 3; n++) begin
            if (cmd_ready) acc++;
            @(posedge gtx_clk);
            #1;
            if (acc == 3) cmd_valid = 1'b0;
            @(negedge gtx_clk);
        end
        cmd_valid = 1'b0;
        chk("b2b accepted", acc, 3);
        for (int n = 0; n < 2000 && done_cnt < base + 3; n++) @(negedge gtx_clk);
        #1;
        if (done_cnt < base + 3) fail("wait b2b frames");
        chk("b2b frame count", lens.size(), 3);
        foreach (lens[k]) chk($sformatf("b2b txen length %0d", k), lens[k], 72);
        chk("b2b gap count", gaps.size(), 2);
        foreach (gaps[k]) chk($sformatf("b2b gap %0d", k), gaps[k], 12);
        chk("b2b crc residue", last_res, 32'hDEBB20E3);
        chk("b2b scoreboard drained", exp_q.size(), 0);
        chk("b2b frame_cnt", frame_cnt, 3);
        repeat (20) @(negedge gtx_clk);
        chk("b2b no extra frame", done_cnt, base + 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
